// File: rtl/vehicle_can_pkg.sv
// Shared definitions for the vehicle CAN generator/receiver pair.
// Holds the default frame IDs, the payload field positions and widths,
// and the receiver FSM state encoding.
package vehicle_can_pkg;

  localparam logic [10:0] DEF_ID_ENGINE_REV = 11'h3D9;
  localparam logic [10:0] DEF_ID_CAR_SPEED  = 11'h3E9;

  localparam int ENGINE_REV_MSB = 47;
  localparam int ENGINE_REV_LSB = 34;
  localparam int CAR_SPEED_MSB  = 63;
  localparam int CAR_SPEED_LSB  = 55;

  localparam int ENGINE_REV_W = 14;
  localparam int CAR_SPEED_W  = 9;

  typedef enum logic [1:0] {
    STATE_WAIT   = 2'b00,
    STATE_DECODE = 2'b01
  } rx_state_e;

endpackage

// File: rtl/stale_timer.sv
// Freshness tracker for one decoded value.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   update     : value written this cycle (restarts freshness window)
//   valid      : high for exactly TIMEOUT_CYCLE cycles after the last update
module stale_timer #(
  parameter int TIMEOUT_CYCLE = 150_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic update,
  output logic valid
);

  localparam int CW = $clog2(TIMEOUT_CYCLE);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLE - 1);

  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;

  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    // An update always wins over an expiry landing on the same edge.
    if (update) begin
      valid_d = 1'b1;
      count_d = '0;
    end else if (valid_q) begin
      if (count_q == LAST) begin
        valid_d = 1'b0;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/vehicle_data_receiver.sv
// Decodes engine-revolution and vehicle-speed CAN frames from an
// AXI4-Stream receive port into held values with freshness flags,
// and counts malformed frames.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   stm_recv_data_in_*         : AXI4-Stream sink (tdata/tid/tkeep/tvalid/tready)
//   engine_rev[_valid/_update] : last accepted engine revolution, freshness, write pulse
//   vehicle_speed[_valid/_update] : last accepted speed, freshness, write pulse
//   frame_error_count          : saturating count of rejected frames
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. tready is driven only from FSM state and reset, never from
// tvalid; it is low for the one decode cycle after each transfer.
module vehicle_data_receiver
  import vehicle_can_pkg::*;
#(
  parameter logic [10:0] ID_ENGINE_REV     = DEF_ID_ENGINE_REV,
  parameter logic [10:0] ID_CAR_SPEED      = DEF_ID_CAR_SPEED,
  parameter int          TIMEOUT_CYCLE     = 150_000_000,
  parameter logic [13:0] MAX_ENGINE_REV    = 14'd12000,
  parameter logic [8:0]  MAX_VEHICLE_SPEED = 9'd300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] stm_recv_data_in_tdata,
  input  logic [10:0] stm_recv_data_in_tid,
  input  logic [7:0]  stm_recv_data_in_tkeep,
  input  logic        stm_recv_data_in_tvalid,
  output logic        stm_recv_data_in_tready,
  output logic [13:0] engine_rev,
  output logic        engine_rev_valid,
  output logic        engine_rev_update,
  output logic [8:0]  vehicle_speed,
  output logic        vehicle_speed_valid,
  output logic        vehicle_speed_update,
  output logic [7:0]  frame_error_count
);

  rx_state_e   state_q, state_d;
  logic [63:0] tdata_q, tdata_d;
  logic [10:0] tid_q, tid_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic [13:0] engine_rev_q, engine_rev_d;
  logic        engine_rev_update_q, engine_rev_update_d;
  logic [8:0]  vehicle_speed_q, vehicle_speed_d;
  logic        vehicle_speed_update_q, vehicle_speed_update_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [ENGINE_REV_W-1:0] eng_field;
  logic [CAR_SPEED_W-1:0]  spd_field;
  logic                    handshake;

  // Payload bits outside both fields are don't-care.
  logic unused_payload_bits;
  assign unused_payload_bits = ^{tdata_q[54:48], tdata_q[33:0]};

  assign stm_recv_data_in_tready = (state_q == STATE_WAIT) && !reset;
  assign handshake = stm_recv_data_in_tvalid && stm_recv_data_in_tready;

  assign eng_field = tdata_q[ENGINE_REV_MSB:ENGINE_REV_LSB];
  assign spd_field = tdata_q[CAR_SPEED_MSB:CAR_SPEED_LSB];

  always_comb begin
    state_d                = state_q;
    tdata_d                = tdata_q;
    tid_d                  = tid_q;
    tkeep_d                = tkeep_q;
    engine_rev_d           = engine_rev_q;
    engine_rev_update_d    = 1'b0;
    vehicle_speed_d        = vehicle_speed_q;
    vehicle_speed_update_d = 1'b0;
    err_cnt_d              = err_cnt_q;
    case (state_q)
      STATE_WAIT: begin
        if (handshake) begin
          tdata_d = stm_recv_data_in_tdata;
          tid_d   = stm_recv_data_in_tid;
          tkeep_d = stm_recv_data_in_tkeep;
          state_d = STATE_DECODE;
        end
      end
      STATE_DECODE: begin
        state_d = STATE_WAIT;
        if (tid_q == ID_ENGINE_REV) begin
          if (tkeep_q == 8'hFF && eng_field <= MAX_ENGINE_REV) begin
            engine_rev_d        = eng_field;
            engine_rev_update_d = 1'b1;
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (tid_q == ID_CAR_SPEED) begin
          if (tkeep_q == 8'hFF && spd_field <= MAX_VEHICLE_SPEED) begin
            vehicle_speed_d        = spd_field;
            vehicle_speed_update_d = 1'b1;
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = STATE_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                <= STATE_WAIT;
      tdata_q                <= '0;
      tid_q                  <= '0;
      tkeep_q                <= '0;
      engine_rev_q           <= '0;
      engine_rev_update_q    <= 1'b0;
      vehicle_speed_q        <= '0;
      vehicle_speed_update_q <= 1'b0;
      err_cnt_q              <= '0;
    end else begin
      state_q                <= state_d;
      tdata_q                <= tdata_d;
      tid_q                  <= tid_d;
      tkeep_q                <= tkeep_d;
      engine_rev_q           <= engine_rev_d;
      engine_rev_update_q    <= engine_rev_update_d;
      vehicle_speed_q        <= vehicle_speed_d;
      vehicle_speed_update_q <= vehicle_speed_update_d;
      err_cnt_q              <= err_cnt_d;
    end
  end

  // The write pulse doubles as the freshness restart so both register on
  // the same edge as the value.
  stale_timer #(.TIMEOUT_CYCLE(TIMEOUT_CYCLE)) u_engine_timer (
    .clk    (clk),
    .reset  (reset),
    .update (engine_rev_update_d),
    .valid  (engine_rev_valid)
  );

  stale_timer #(.TIMEOUT_CYCLE(TIMEOUT_CYCLE)) u_speed_timer (
    .clk    (clk),
    .reset  (reset),
    .update (vehicle_speed_update_d),
    .valid  (vehicle_speed_valid)
  );

  assign engine_rev           = engine_rev_q;
  assign engine_rev_update    = engine_rev_update_q;
  assign vehicle_speed        = vehicle_speed_q;
  assign vehicle_speed_update = vehicle_speed_update_q;
  assign frame_error_count    = err_cnt_q;

endmodule

// File: tb/tb_vehicle_data_receiver.sv
module tb_vehicle_data_receiver;

  localparam logic [10:0] ID_E = 11'h3D9;
  localparam logic [10:0] ID_S = 11'h3E9;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] tdata;
  logic [10:0] tid;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic [13:0] engine_rev;
  logic        engine_rev_valid;
  logic        engine_rev_update;
  logic [8:0]  vehicle_speed;
  logic        vehicle_speed_valid;
  logic        vehicle_speed_update;
  logic [7:0]  frame_error_count;

  int tests_run  = 0;
  int fail_count = 0;
  int cyc        = 0;

  vehicle_data_receiver #(.TIMEOUT_CYCLE(100)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .stm_recv_data_in_tdata  (tdata),
    .stm_recv_data_in_tid    (tid),
    .stm_recv_data_in_tkeep  (tkeep),
    .stm_recv_data_in_tvalid (tvalid),
    .stm_recv_data_in_tready (tready),
    .engine_rev              (engine_rev),
    .engine_rev_valid        (engine_rev_valid),
    .engine_rev_update       (engine_rev_update),
    .vehicle_speed           (vehicle_speed),
    .vehicle_speed_valid     (vehicle_speed_valid),
    .vehicle_speed_update    (vehicle_speed_update),
    .frame_error_count       (frame_error_count)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] eng_data(input int v);
    logic [63:0] x;
    x = 64'(v);
    return x << 34;
  endfunction

  function automatic logic [63:0] spd_data(input int v);
    logic [63:0] x;
    x = 64'(v);
    return x << 55;
  endfunction

  // Driver: present a beat, wait (bounded) for tready, return just after
  // the handshake edge with tvalid dropped.
  task automatic send_beat(input logic [10:0] id, input logic [63:0] d, input logic [7:0] k);
    int waited;
    tid = id; tdata = d; tkeep = k; tvalid = 1'b1;
    waited = 0;
    while (tready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (waited >= 20) check("handshake_timeout", 32'(waited), 32'd0);
    step();
    tvalid = 1'b0;
  endtask

  logic [10:0] bb_id  [4];
  int          bb_val [4];

  initial begin
    int hi;
    int drops;
    int last_hs;
    int waited;
    logic [63:0] mask;

    reset = 1'b1; tvalid = 1'b0; tdata = '0; tid = '0; tkeep = '0;
    repeat (3) step();
    check("rst_tready",      32'(tready), 32'd0);
    check("rst_engine_rev",  32'(engine_rev), 32'd0);
    check("rst_eng_valid",   32'(engine_rev_valid), 32'd0);
    check("rst_eng_update",  32'(engine_rev_update), 32'd0);
    check("rst_speed",       32'(vehicle_speed), 32'd0);
    check("rst_spd_valid",   32'(vehicle_speed_valid), 32'd0);
    check("rst_spd_update",  32'(vehicle_speed_update), 32'd0);
    check("rst_err_count",   32'(frame_error_count), 32'd0);
    reset = 1'b0;
    #1;
    check("tready_after_rst", 32'(tready), 32'd1);

    // Engine frame 3000
    send_beat(ID_E, eng_data(3000), 8'hFF);
    check("eng_decode_tready", 32'(tready), 32'd0);
    check("eng_early_update",  32'(engine_rev_update), 32'd0);
    step();
    check("eng_value",    32'(engine_rev), 32'd3000);
    check("eng_valid",    32'(engine_rev_valid), 32'd1);
    check("eng_update",   32'(engine_rev_update), 32'd1);
    check("eng_tready_back", 32'(tready), 32'd1);
    step();
    check("eng_update_1cyc", 32'(engine_rev_update), 32'd0);
    check("eng_value_hold",  32'(engine_rev), 32'd3000);

    // Speed 120 accepted, 301 rejected
    send_beat(ID_S, spd_data(120), 8'hFF);
    step();
    check("spd_120",        32'(vehicle_speed), 32'd120);
    check("spd_120_update", 32'(vehicle_speed_update), 32'd1);
    send_beat(ID_S, spd_data(301), 8'hFF);
    step();
    check("spd_301_hold",   32'(vehicle_speed), 32'd120);
    check("spd_301_noupd",  32'(vehicle_speed_update), 32'd0);
    check("spd_301_valid",  32'(vehicle_speed_valid), 32'd1);
    check("err_after_301",  32'(frame_error_count), 32'd1);

    // Engine frame with partial tkeep
    send_beat(ID_E, eng_data(5000), 8'h0F);
    step();
    check("eng_tkeep_hold", 32'(engine_rev), 32'd3000);
    check("err_after_tkeep", 32'(frame_error_count), 32'd2);

    // Unknown ID
    send_beat(11'h123, eng_data(7), 8'hFF);
    check("other_id_consumed", 32'(tready), 32'd0);
    step();
    check("other_id_eng",   32'(engine_rev), 32'd3000);
    check("other_id_spd",   32'(vehicle_speed), 32'd120);
    check("other_id_err",   32'(frame_error_count), 32'd2);
    check("other_id_eupd",  32'(engine_rev_update), 32'd0);
    check("other_id_supd",  32'(vehicle_speed_update), 32'd0);

    // Range boundaries
    send_beat(ID_E, eng_data(12000), 8'hFF);
    step();
    check("eng_max_accept", 32'(engine_rev), 32'd12000);
    send_beat(ID_E, eng_data(12001), 8'hFF);
    step();
    check("eng_over_hold",  32'(engine_rev), 32'd12000);
    check("err_after_12001", 32'(frame_error_count), 32'd3);
    send_beat(ID_S, spd_data(300), 8'hFF);
    step();
    check("spd_max_accept", 32'(vehicle_speed), 32'd300);

    // Don't-care bits outside the engine field set to ones
    mask = ~(64'h3FFF << 34);
    send_beat(ID_E, mask | eng_data(1234), 8'hFF);
    step();
    check("eng_dontcare", 32'(engine_rev), 32'd1234);
    check("err_dontcare", 32'(frame_error_count), 32'd3);

    // Timeout: valid for exactly 100 cycles after the last update
    send_beat(ID_S, spd_data(77), 8'hFF);
    step();
    hi = 0;
    for (int i = 0; i < 150; i++) begin
      if (vehicle_speed_valid === 1'b1) hi++;
      step();
    end
    check("spd_valid_cycles", 32'(hi), 32'd100);
    check("spd_timeout_valid", 32'(vehicle_speed_valid), 32'd0);
    check("spd_timeout_hold", 32'(vehicle_speed), 32'd77);

    // Update landing on the expiry edge keeps valid high
    send_beat(ID_S, spd_data(88), 8'hFF);
    step();
    drops = 0;
    if (vehicle_speed_valid !== 1'b1) drops++;
    for (int i = 0; i < 98; i++) begin
      step();
      if (vehicle_speed_valid !== 1'b1) drops++;
    end
    tid = ID_S; tdata = spd_data(89); tkeep = 8'hFF; tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    if (vehicle_speed_valid !== 1'b1) drops++;
    step();
    check("spd_late_update", 32'(vehicle_speed_update), 32'd1);
    check("spd_late_value",  32'(vehicle_speed), 32'd89);
    for (int i = 0; i < 60; i++) begin
      if (vehicle_speed_valid !== 1'b1) drops++;
      step();
    end
    check("spd_no_drop", 32'(drops), 32'd0);

    // Back-to-back beats with tvalid held high
    bb_id[0] = ID_E; bb_val[0] = 1000;
    bb_id[1] = ID_S; bb_val[1] = 50;
    bb_id[2] = ID_E; bb_val[2] = 2000;
    bb_id[3] = ID_S; bb_val[3] = 60;
    tid = bb_id[0];
    tdata = (bb_id[0] == ID_E) ? eng_data(bb_val[0]) : spd_data(bb_val[0]);
    tkeep = 8'hFF; tvalid = 1'b1;
    last_hs = 0;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (tready !== 1'b1 && waited < 20) begin
        step();
        waited++;
      end
      if (waited >= 20) check("bb_handshake_timeout", 32'(waited), 32'd0);
      if (i > 0) check("bb_spacing", 32'(cyc - last_hs), 32'd2);
      last_hs = cyc;
      step();
      if (i < 3) begin
        tid = bb_id[i+1];
        tdata = (bb_id[i+1] == ID_E) ? eng_data(bb_val[i+1]) : spd_data(bb_val[i+1]);
      end else begin
        tvalid = 1'b0;
      end
      step();
      if (bb_id[i] == ID_E) begin
        check("bb_eng_value",  32'(engine_rev), 32'(bb_val[i]));
        check("bb_eng_update", 32'(engine_rev_update), 32'd1);
      end else begin
        check("bb_spd_value",  32'(vehicle_speed), 32'(bb_val[i]));
        check("bb_spd_update", 32'(vehicle_speed_update), 32'd1);
      end
    end

    // Reset asserted while in decode
    send_beat(ID_E, eng_data(4321), 8'h0F);
    reset = 1'b1;
    step();
    check("rdec_update",  32'(engine_rev_update), 32'd0);
    check("rdec_eng",     32'(engine_rev), 32'd0);
    check("rdec_evalid",  32'(engine_rev_valid), 32'd0);
    check("rdec_spd",     32'(vehicle_speed), 32'd0);
    check("rdec_svalid",  32'(vehicle_speed_valid), 32'd0);
    check("rdec_err",     32'(frame_error_count), 32'd0);
    check("rdec_tready",  32'(tready), 32'd0);
    reset = 1'b0;
    step();
    check("rdec_after_upd", 32'(engine_rev_update), 32'd0);
    check("rdec_after_err", 32'(frame_error_count), 32'd0);
    check("rdec_after_tready", 32'(tready), 32'd1);

    // Error counter saturation
    for (int i = 0; i < 254; i++) send_beat(ID_E, eng_data(100), 8'h00);
    step();
    check("err_254", 32'(frame_error_count), 32'd254);
    send_beat(ID_S, spd_data(400), 8'hFF);
    step();
    check("err_255", 32'(frame_error_count), 32'd255);
    for (int i = 0; i < 5; i++) send_beat(ID_E, eng_data(100), 8'h00);
    step();
    check("err_saturated", 32'(frame_error_count), 32'd255);
    check("err_sat_eng",   32'(engine_rev), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/vehicle_data_receiver.md
# vehicle_data_receiver

Receive-side counterpart to the vehicle data generator. The block consumes received CAN frames from the CAN receiver's AXI4-Stream output and decodes the engine-revolution frame (ID 0x3D9) and the vehicle-speed frame (ID 0x3E9) into held register values for the dashboard and display logic. Each value carries a freshness flag that drops when its frame stops arriving. The block also counts malformed frames for diagnostics.

## Interface
Parameters:
- `ID_ENGINE_REV`, 11'h3D9, CAN ID of the engine-revolution frame
- `ID_CAR_SPEED`, 11'h3E9, CAN ID of the vehicle-speed frame
- `TIMEOUT_CYCLE`, 150_000_000, number of cycles without an update before a value is flagged stale
- `MAX_ENGINE_REV`, 14'd12000, largest accepted engine revolution; larger values are rejected
- `MAX_VEHICLE_SPEED`, 9'd300, largest accepted speed; larger values are rejected

Ports:
- `clk` in 1 — single clock
- `reset` in 1 — synchronous, active-high reset
- `stm_recv_data_in_tdata` in 64 — received payload, byte 7 in bits [63:56]
- `stm_recv_data_in_tid` in 11 — received CAN ID
- `stm_recv_data_in_tkeep` in 8 — valid-byte mask of the payload
- `stm_recv_data_in_tvalid` in 1
- `stm_recv_data_in_tready` out 1
- `engine_rev` out 14 — last accepted engine revolution
- `engine_rev_valid` out 1 — 1 while `engine_rev` is fresh
- `engine_rev_update` out 1 — one-cycle pulse when `engine_rev` is written
- `vehicle_speed` out 9 — last accepted speed
- `vehicle_speed_valid` out 1 — 1 while `vehicle_speed` is fresh
- `vehicle_speed_update` out 1 — one-cycle pulse when `vehicle_speed` is written
- `frame_error_count` out 8 — saturating count of rejected frames

## Operation
- FSM with two states:
  - STATE_WAIT: `tready`=1. A handshake (`tvalid & tready`) captures tdata, tid and tkeep into the beat registers and moves to STATE_DECODE.
  - STATE_DECODE: `tready`=0. Decodes the captured beat in one cycle and always returns to STATE_WAIT.
  - Any unused state encoding returns to STATE_WAIT.
- Engine-revolution frame (tid==`ID_ENGINE_REV`):
  - field = tdata[47:34]
  - Reject if tkeep != 8'hFF or field > `MAX_ENGINE_REV`.
- Speed frame (tid==`ID_CAR_SPEED`):
  - field = tdata[63:55]
  - Reject if tkeep != 8'hFF or field > `MAX_VEHICLE_SPEED`.
- Bits outside each field are don't-care and are not checked.
- On accept:
  - Write the value, set the matching `_valid`, pulse `_update`, clear that channel's stale timer.
- On reject:
  - Value and valid flag are unchanged.
  - `frame_error_count` increments, saturating at 255.
- Any other tid: the frame is consumed silently; no counter or output changes.
- Stale timer, one per channel:
  - Counts cycles while `_valid`=1.
  - When it reaches `TIMEOUT_CYCLE`-1 with no update in that cycle, `_valid` clears. The value is held.
  - `_valid` therefore stays high for exactly `TIMEOUT_CYCLE` cycles after the last update.
- If an update and a timeout fall on the same cycle, the update wins: `_valid` stays 1 and the timer restarts at 0.

## Timing
- Reset values:
  - state = STATE_WAIT
  - `tready`=0 while `reset`=1, and 1 from the first cycle after `reset` deasserts
  - `engine_rev`=0, `vehicle_speed`=0
  - both `_valid`=0, both `_update`=0
  - `frame_error_count`=0
  - both stale timers = 0
- Latency: handshake at clock edge N → value, `_valid` and `_update` are registered at edge N+1. `_update` is high for the single cycle following edge N+1.
- Throughput: at most one beat every 2 cycles, because `tready` is low in the cycle after each handshake.
- AXI rules:
  - `tready` never depends combinationally on `tvalid`.
  - The upstream source holds tdata, tid and tkeep stable while `tvalid`=1 and `tready`=0.
- Reset asserted in STATE_DECODE: the captured beat is discarded and produces no update and no error count.
- The counter width is $clog2(`TIMEOUT_CYCLE`) bits. `TIMEOUT_CYCLE` ≥ 2.

## Structure
- Shared package `vehicle_can_pkg`, also imported by the generator:
  - default IDs 0x3D9 and 0x3E9
  - field positions: ENGINE_REV_MSB/LSB = 47/34, CAR_SPEED_MSB/LSB = 63/55
  - field widths 14 and 9
  - receiver state enum
- Sub-module `stale_timer`:
  - parameter `TIMEOUT_CYCLE`
  - inputs `clk`, `reset`, `update`
  - output `valid`
  - instantiated once per channel

## Test plan
- Engine frame: tid=0x3D9, tkeep=FF, tdata[47:34]=3000 → one edge after the handshake, `engine_rev`=3000, `engine_rev_valid`=1, `engine_rev_update` pulses for 1 cycle; `tready` is 0 for exactly 1 cycle.
- Speed frame 120, then a speed frame 301 → 120 is accepted; 301 is rejected, `vehicle_speed` stays 120, `frame_error_count`=1.
- Engine frame with tkeep=8'h0F → rejected, count increments; a frame with tid=0x123 → no output change, `tready` handshake still completes.
- `TIMEOUT_CYCLE`=100: one speed update, then silence → `vehicle_speed_valid` is 1 for exactly 100 cycles, then 0 with the value held. A second run with an update landing exactly on cycle 100 → valid never drops.
- tvalid held high with back-to-back beats → accepted every 2 cycles, all values decoded in order. Reset asserted in STATE_DECODE → no update pulse, all outputs return to reset values.
- 260 malformed frames → `frame_error_count` saturates at 255.
